matmul_m0_read_sched: RTL and testbench

Read scheduler for the M0 operand of the floating-point matrix multiplier. On a `start` pulse it walks the M0 address space (row-block × column) once per output pass. It drives the `row`/`column`/`rd_en` inputs of the M0 bank-read pipeline, with per-cycle stall support. After the last issue it waits for that pipeline to drain, then pulses `done`. It sits between the top-level multiply controller and the M0 read pipeline, which staggers enables across the N banks.

---
 rtl/matmul_m0_read_sched_if.sv | 34 +++
 rtl/matmul_m0_read_sched.sv | 158 +++++++++++++++
 tb/tb_matmul_m0_read_sched.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/matmul_m0_read_sched_if.sv
// Interface bundling the control/issue signals of the M0 read scheduler.
//   master : multiply controller side (drives start/abort/stall, observes issue)
//   slave  : scheduler side (observes start/abort/stall, drives issue outputs)
//   start/abort/stall        : job request, synchronous cancel, back-pressure
//   row/column/rd_en         : address and enable to the M0 bank-read pipeline
//   pass_idx/first_k/last_k  : pass number and accumulator clear/commit markers
//   busy/done                : job in progress, one-cycle completion pulse
interface matmul_m0_read_sched_if #(
    parameter int unsigned N      = 3,
    parameter int unsigned M      = 6,
    parameter int unsigned PASSES = 6
);
    logic                        start;
    logic                        abort;
    logic                        stall;
    logic [$clog2(M/N)-1:0]      row;
    logic [$clog2(M)-1:0]        column;
    logic                        rd_en;
    logic [$clog2(PASSES)-1:0]   pass_idx;
    logic                        first_k;
    logic                        last_k;
    logic                        busy;
    logic                        done;

    modport master (
        output start, abort, stall,
        input  row, column, rd_en, pass_idx, first_k, last_k, busy, done
    );

    modport slave (
        input  start, abort, stall,
        output row, column, rd_en, pass_idx, first_k, last_k, busy, done
    );
endinterface

// File: rtl/matmul_m0_read_sched.sv
// M0 operand read scheduler for the floating-point matrix multiplier.
// On start, sweeps column (inner), row-block, pass (outer) once per job,
// issuing one address per unstalled cycle, then waits N+2 cycles for the
// N-deep bank-read pipeline to drain and pulses done.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of matmul_m0_read_sched_if (see interface header)
module matmul_m0_read_sched #(
    parameter int unsigned N      = 3,
    parameter int unsigned M      = 6,
    parameter int unsigned PASSES = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    matmul_m0_read_sched_if.slave         bus
);
    localparam int unsigned RB = M / N;
    localparam int unsigned RW = $clog2(RB);
    localparam int unsigned CW = $clog2(M);
    localparam int unsigned PW = $clog2(PASSES);
    localparam int unsigned DW = $clog2(N + 2);

    localparam logic [CW-1:0] K_MAX = CW'(M - 1);
    localparam logic [RW-1:0] R_MAX = RW'(RB - 1);
    localparam logic [PW-1:0] P_MAX = PW'(PASSES - 1);
    localparam logic [DW-1:0] D_MAX = DW'(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] k;
    logic [RW-1:0] r;
    logic [PW-1:0] p;
    logic [DW-1:0] dcnt;

    logic [RW-1:0] row_q;
    logic [CW-1:0] column_q;
    logic [PW-1:0] pass_q;
    logic          rd_en_q;
    logic          first_q;
    logic          last_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            k        <= '0;
            r        <= '0;
            p        <= '0;
            dcnt     <= '0;
            row_q    <= '0;
            column_q <= '0;
            pass_q   <= '0;
            rd_en_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.abort) begin
            // Cancel wins over start and stall in every state; no done pulse.
            state   <= S_IDLE;
            k       <= '0;
            r       <= '0;
            p       <= '0;
            dcnt    <= '0;
            rd_en_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    k       <= '0;
                    r       <= '0;
                    p       <= '0;
                    dcnt    <= '0;
                    rd_en_q <= 1'b0;
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        state  <= S_ISSUE;
                        busy_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.stall) begin
                        // Address outputs and counters hold while stalled.
                        rd_en_q <= 1'b0;
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else begin
                        row_q    <= r;
                        column_q <= k;
                        pass_q   <= p;
                        rd_en_q  <= 1'b1;
                        first_q  <= (k == '0);
                        last_q   <= (k == K_MAX);
                        if (k == K_MAX) begin
                            k <= '0;
                            if (r == R_MAX) begin
                                r <= '0;
                                if (p == P_MAX) begin
                                    p     <= '0;
                                    dcnt  <= '0;
                                    state <= S_DRAIN;
                                end else begin
                                    p <= p + 1'b1;
                                end
                            end else begin
                                r <= r + 1'b1;
                            end
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    rd_en_q <= 1'b0;
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                    if (dcnt == D_MAX) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.row      = row_q;
    assign bus.column   = column_q;
    assign bus.pass_idx = pass_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.first_k  = first_q;
    assign bus.last_k   = last_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_matmul_m0_read_sched.sv
// Directed self-checking bench for matmul_m0_read_sched (M=6, N=3, PASSES=2).
// Inputs change 1 time unit after a rising edge ("driven at edge e") and are
// sampled at edge e+1; outputs are checked 1 time unit after each edge.
module tb_matmul_m0_read_sched;
    localparam int unsigned N      = 3;
    localparam int unsigned M      = 6;
    localparam int unsigned PASSES = 2;
    localparam int TOTAL = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    matmul_m0_read_sched_if #(.N(N), .M(M), .PASSES(PASSES)) bus ();

    matmul_m0_read_sched #(.N(N), .M(M), .PASSES(PASSES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_en"},    32'(bus.rd_en),    32'd0);
        chk({tag, " busy"},     32'(bus.busy),     32'd0);
        chk({tag, " done"},     32'(bus.done),     32'd0);
        chk({tag, " row"},      32'(bus.row),      32'd0);
        chk({tag, " column"},   32'(bus.column),   32'd0);
        chk({tag, " pass_idx"}, 32'(bus.pass_idx), 32'd0);
        chk({tag, " first_k"},  32'(bus.first_k),  32'd0);
        chk({tag, " last_k"},   32'(bus.last_k),   32'd0);
    endtask

    // One job with start driven at edge 0. Stall is driven high at edges
    // st_lo..st_hi, extra starts at edges s1/s2; done must appear only at done_at.
    task automatic run_job(input string tag, input int st_lo, input int st_hi,
                           input int s1, input int s2, input int done_at);
        int issued;
        int seen;
        int prev_stall;
        int last_col;
        int last_row;
        logic exp_rd;
        issued     = 0;
        seen       = 0;
        last_col   = 0;
        last_row   = 0;
        bus.start  = 1'b1;
        bus.stall  = (0 >= st_lo && 0 <= st_hi);
        prev_stall = 0;
        for (int c = 1; c <= done_at + 3; c++) begin
            prev_stall = int'(bus.stall);
            tick();
            exp_rd = (c >= 2) && (issued < TOTAL) && (prev_stall == 0);
            if (bus.rd_en === 1'b1) seen++;
            chk($sformatf("%s rd_en c%0d", tag, c), 32'(bus.rd_en), 32'(exp_rd));
            if (exp_rd) begin
                last_col = issued % 6;
                last_row = (issued / 6) % 2;
                chk($sformatf("%s column c%0d", tag, c),   32'(bus.column),   32'(last_col));
                chk($sformatf("%s row c%0d", tag, c),      32'(bus.row),      32'(last_row));
                chk($sformatf("%s pass_idx c%0d", tag, c), 32'(bus.pass_idx), 32'(issued / 12));
                chk($sformatf("%s first_k c%0d", tag, c),  32'(bus.first_k),  32'(last_col == 0));
                chk($sformatf("%s last_k c%0d", tag, c),   32'(bus.last_k),   32'(last_col == 5));
                issued++;
            end else if (issued > 0 && issued < TOTAL) begin
                chk($sformatf("%s hold column c%0d", tag, c), 32'(bus.column), 32'(last_col));
                chk($sformatf("%s hold row c%0d", tag, c),    32'(bus.row),    32'(last_row));
                chk($sformatf("%s stall first_k c%0d", tag, c), 32'(bus.first_k), 32'd0);
            end
            chk($sformatf("%s done c%0d", tag, c), 32'(bus.done), 32'(c == done_at));
            chk($sformatf("%s busy c%0d", tag, c), 32'(bus.busy), 32'(c >= 1 && c <= done_at));
            bus.stall = (c >= st_lo && c <= st_hi);
            bus.start = (c == s1 || c == s2);
        end
        chk({tag, " issue count"}, 32'(seen), 32'(TOTAL));
        bus.stall = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        int found;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.stall = 1'b0;

        // Reset values
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        chk_all_zero("reset held");
        rst_n = 1'b1;
        tick();

        // Basic run, no stall
        run_job("basic", -1, -1, -1, -1, 30);
        tick();

        // Stall at edges 5..7
        run_job("stall", 5, 7, -1, -1, 33);
        tick();

        // Ignored starts at 3 and 28
        run_job("restart", -1, -1, 3, 28, 30);
        tick();

        // Stall held through drain from cycle 25
        run_job("drainstall", 25, 100000, -1, -1, 30);
        tick();

        // Abort mid-ISSUE at edge 10, re-start at edge 12
        bus.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            bus.start = 1'b0;
        end
        chk("abort pre rd_en", 32'(bus.rd_en), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort c11 rd_en", 32'(bus.rd_en), 32'd0);
        chk("abort c11 busy",  32'(bus.busy),  32'd0);
        chk("abort c11 done",  32'(bus.done),  32'd0);
        tick();
        chk("abort c12 busy",  32'(bus.busy),  32'd0);
        chk("abort c12 done",  32'(bus.done),  32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("abort c13 busy",  32'(bus.busy),  32'd1);
        chk("abort c13 rd_en", 32'(bus.rd_en), 32'd0);
        tick();
        chk("reissue rd_en",    32'(bus.rd_en),    32'd1);
        chk("reissue row",      32'(bus.row),      32'd0);
        chk("reissue column",   32'(bus.column),   32'd0);
        chk("reissue pass_idx", 32'(bus.pass_idx), 32'd0);
        chk("reissue first_k",  32'(bus.first_k),  32'd1);
        found = 0;
        for (int c = 15; c <= 60 && found == 0; c++) begin
            tick();
            if (bus.done === 1'b1) found = c;
        end
        chk("reissue done cycle", 32'(found), 32'd42);
        tick();
        tick();

        // start and abort together in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        chk("start+abort busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        chk("start+abort busy2",  32'(bus.busy),  32'd0);
        chk("start+abort rd_en2", 32'(bus.rd_en), 32'd0);

        // Reset mid-DRAIN at cycle 27
        bus.start = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            tick();
            bus.start = 1'b0;
        end
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        found = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.done === 1'b1) found = 1;
        end
        chk("no done in reset", 32'(found), 32'd0);

        // start held through reset release is taken on the first edge
        bus.start = 1'b1;
        rst_n = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start thru reset busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("cleanup abort busy", 32'(bus.busy), 32'd0);
        tick();

        // Fresh run after reset matches basic run
        run_job("post-reset", -1, -1, -1, -1, 30);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
